// File: rtl/invader_hit_detect.sv
// Player-bullet vs. invader-formation hit detector.
// One invader is examined per clock in row-major order; the first live hit is killed and reported.
module invader_hit_detect #(
    parameter int ROWS      = 5,
    parameter int COLS      = 11,
    parameter int INV_W     = 16,
    parameter int INV_H     = 8,
    parameter int SPACING_X = 24,
    parameter int SPACING_Y = 16,
    parameter int BULLET_W  = 2,
    parameter int BULLET_H  = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 frame,
    input  logic [9:0]           invaders_x,
    input  logic [9:0]           invaders_y,
    input  logic                 bullet_valid,
    input  logic [9:0]           bullet_x,
    input  logic [9:0]           bullet_y,
    input  logic                 wave_reset,
    output logic                 invader_collision,
    output logic [2:0]           hit_row,
    output logic [3:0]           hit_col,
    output logic [ROWS*COLS-1:0] alive,
    output logic [5:0]           alive_count,
    output logic                 all_dead,
    output logic                 busy
);

    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [9:0]  ox_q;
    logic [9:0]  oy_q;
    logic [9:0]  bx_q;
    logic [9:0]  by_q;
    logic [2:0]  row_q;
    logic [3:0]  col_q;
    logic [5:0]  idx_q;

    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] bx_e;
    logic [10:0] by_e;
    logic        start;
    logic        last;
    logic        scan_hit;

    // Box test for the invader currently addressed by (row_q, col_q) / idx_q.
    always_comb begin
        bx_e     = {1'b0, bx_q};
        by_e     = {1'b0, by_q};
        x0       = {1'b0, ox_q} + 11'(col_q) * 11'(SPACING_X);
        y0       = {1'b0, oy_q} + 11'(row_q) * 11'(SPACING_Y);
        last     = (idx_q == 6'(N - 1));
        start    = (state == IDLE) && frame && bullet_valid && !all_dead && !wave_reset;
        scan_hit = (state == SCAN) && alive[idx_q]
                   && (bx_e < x0 + 11'(INV_W))
                   && (bx_e + 11'(BULLET_W) > x0)
                   && (by_e < y0 + 11'(INV_H))
                   && (by_e + 11'(BULLET_H) > y0);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    state_nx = REPORT;
                end else if (last) begin
                    state_nx = IDLE;
                end
            end
            REPORT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (wave_reset) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        invader_collision = (state == REPORT);
        busy              = (state != IDLE);
    end

    always_comb begin
        all_dead = (alive_count == '0);
    end

    // Scan snapshot and position counters; idx_q tracks row_q*COLS+col_q.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ox_q  <= '0;
            oy_q  <= '0;
            bx_q  <= '0;
            by_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else if (start) begin
            ox_q  <= invaders_x;
            oy_q  <= invaders_y;
            bx_q  <= bullet_x;
            by_q  <= bullet_y;
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else if (state == SCAN && !scan_hit && !last && !wave_reset) begin
            idx_q <= idx_q + 6'd1;
            if (col_q == 4'(COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + 3'd1;
            end else begin
                col_q <= col_q + 4'd1;
            end
        end
    end

    // wave_reset outranks a same-cycle hit; hit_row/hit_col keep their last value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alive       <= '1;
            alive_count <= 6'(N);
            hit_row     <= '0;
            hit_col     <= '0;
        end else if (wave_reset) begin
            alive       <= '1;
            alive_count <= 6'(N);
        end else if (scan_hit) begin
            alive[idx_q] <= 1'b0;
            alive_count  <= alive_count - 6'd1;
            hit_row      <= row_q;
            hit_col      <= col_q;
        end
    end

endmodule

// File: tb/tb_invader_hit_detect.sv
// Directed bench for invader_hit_detect: a frame-level reference model checked every cycle,
// plus hand-computed expectations for the listed scenarios.
module tb_invader_hit_detect;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        frame = 1'b0;
    logic [9:0]  invaders_x = '0;
    logic [9:0]  invaders_y = '0;
    logic        bullet_valid = 1'b0;
    logic [9:0]  bullet_x = '0;
    logic [9:0]  bullet_y = '0;
    logic        wave_reset = 1'b0;
    logic        invader_collision;
    logic [2:0]  hit_row;
    logic [3:0]  hit_col;
    logic [54:0] alive;
    logic [5:0]  alive_count;
    logic        all_dead;
    logic        busy;

    int checks = 0;
    int errors = 0;

    invader_hit_detect #(
        .ROWS(5), .COLS(11), .INV_W(16), .INV_H(8),
        .SPACING_X(24), .SPACING_Y(16), .BULLET_W(2), .BULLET_H(8)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .frame(frame),
        .invaders_x(invaders_x),
        .invaders_y(invaders_y),
        .bullet_valid(bullet_valid),
        .bullet_x(bullet_x),
        .bullet_y(bullet_y),
        .wave_reset(wave_reset),
        .invader_collision(invader_collision),
        .hit_row(hit_row),
        .hit_col(hit_col),
        .alive(alive),
        .alive_count(alive_count),
        .all_dead(all_dead),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the whole frame outcome is decided at start, then a cycle budget runs out.
    logic [54:0] m_alive = '1;
    int          m_count = 55;
    logic        m_busy = 1'b0;
    logic        m_report = 1'b0;
    int          m_t = 0;
    int          m_k = -1;
    int          m_row = 0;
    int          m_col = 0;

    function automatic int first_hit(int ox, int oy, int bx, int by, logic [54:0] al);
        for (int k = 0; k < 55; k++) begin
            int x0;
            int y0;
            x0 = ox + (k % 11) * 24;
            y0 = oy + (k / 11) * 16;
            if (al[k] && bx < x0 + 16 && bx + 2 > x0 && by < y0 + 8 && by + 8 > y0)
                return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_alive  <= '1;
            m_count  <= 55;
            m_busy   <= 1'b0;
            m_report <= 1'b0;
            m_t      <= 0;
            m_k      <= -1;
            m_row    <= 0;
            m_col    <= 0;
        end else if (wave_reset) begin
            m_alive  <= '1;
            m_count  <= 55;
            m_busy   <= 1'b0;
            m_report <= 1'b0;
        end else if (m_report) begin
            m_report <= 1'b0;
        end else if (m_busy) begin
            if (m_t == ((m_k < 0) ? 54 : m_k)) begin
                m_busy <= 1'b0;
                if (m_k >= 0) begin
                    m_report     <= 1'b1;
                    m_alive[m_k] <= 1'b0;
                    m_count      <= m_count - 1;
                    m_row        <= m_k / 11;
                    m_col        <= m_k % 11;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end else if (frame && bullet_valid && m_count != 0) begin
            m_busy <= 1'b1;
            m_t    <= 0;
            m_k    <= first_hit(int'(invaders_x), int'(invaders_y),
                                int'(bullet_x), int'(bullet_y), m_alive);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_alive(input string name, input logic [54:0] exp);
        checks++;
        if (alive !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, alive, exp, $time);
        end
    endtask

    task automatic compare();
        chk("cmp_collision", int'(invader_collision), int'(m_report));
        chk("cmp_busy", int'(busy), int'(m_busy | m_report));
        chk("cmp_count", int'(alive_count), m_count);
        chk("cmp_all_dead", int'(all_dead), int'(m_count == 0));
        chk("cmp_hit_row", int'(hit_row), m_row);
        chk("cmp_hit_col", int'(hit_col), m_col);
        chk_alive("cmp_alive", m_alive);
    endtask

    task automatic do_frame(input int ox, input int oy, input int bx, input int by);
        invaders_x   = 10'(ox);
        invaders_y   = 10'(oy);
        bullet_x     = 10'(bx);
        bullet_y     = 10'(by);
        bullet_valid = 1'b1;
        frame        = 1'b1;
        @(posedge clk); #1;
        frame        = 1'b0;
    endtask

    // Cycle numbers count from the frame cycle (0); inputs are scrambled mid-scan on purpose.
    task automatic wait_scan(output int pulse_c, output int idle_c);
        pulse_c = -1;
        idle_c  = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 2) begin
                invaders_x = '0;
                invaders_y = '0;
                bullet_x   = 10'd1;
                bullet_y   = 10'd1;
            end
            if (invader_collision && pulse_c < 0) pulse_c = c;
            if (!busy) begin
                idle_c = c;
                break;
            end
        end
        if (idle_c < 0) chk("scan_timeout", idle_c, 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_wave_reset();
        wave_reset = 1'b1;
        @(posedge clk); #1;
        wave_reset = 1'b0;
    endtask

    initial begin
        int p;
        int i;
        int seen;
        logic [54:0] exp_alive;

        #2 arst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_collision", int'(invader_collision), 0);
        chk("rst_count", int'(alive_count), 55);
        chk("rst_hit_row", int'(hit_row), 0);
        chk("rst_hit_col", int'(hit_col), 0);
        chk_alive("rst_alive", '1);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        // Hit on invader (0,0)
        do_frame(40, 32, 41, 33);
        wait_scan(p, i);
        chk("s1_pulse_cycle", p, 2);
        chk("s1_hit_row", int'(hit_row), 0);
        chk("s1_hit_col", int'(hit_col), 0);
        chk("s1_alive0", int'(alive[0]), 0);
        chk("s1_count", int'(alive_count), 54);

        // Hit on the last invader (4,10)
        do_frame(40, 32, 285, 98);
        wait_scan(p, i);
        chk("s2_pulse_cycle", p, 56);
        chk("s2_hit_row", int'(hit_row), 4);
        chk("s2_hit_col", int'(hit_col), 10);
        chk("s2_alive54", int'(alive[54]), 0);
        chk("s2_count", int'(alive_count), 53);

        // Bullet in the column gap: full miss
        do_frame(40, 32, 56, 33);
        wait_scan(p, i);
        exp_alive = '1;
        exp_alive[0] = 1'b0;
        exp_alive[54] = 1'b0;
        chk("s3_no_pulse", p, -1);
        chk("s3_idle_cycle", i, 56);
        chk_alive("s3_alive", exp_alive);

        // Frame without a bullet does nothing
        bullet_valid = 1'b0;
        frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        @(negedge clk);
        chk("novalid_busy", int'(busy), 0);
        @(posedge clk); #1;

        // Dead target, then revive and hit again
        do_frame(40, 32, 41, 33);
        wait_scan(p, i);
        chk("s4_dead_no_pulse", p, -1);
        chk("s4_dead_idle", i, 56);
        pulse_wave_reset();
        chk_alive("s4_revived", '1);
        chk("s4_count55", int'(alive_count), 55);
        do_frame(40, 32, 41, 33);
        wait_scan(p, i);
        chk("s4_rehit_cycle", p, 2);
        chk("s4_rehit_count", int'(alive_count), 54);

        // wave_reset coincident with frame: revive only
        invaders_x = 10'd40; invaders_y = 10'd32; bullet_x = 10'd285; bullet_y = 10'd98;
        bullet_valid = 1'b1;
        frame = 1'b1;
        wave_reset = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        wave_reset = 1'b0;
        @(negedge clk);
        chk("wr_frame_busy", int'(busy), 0);
        chk_alive("wr_frame_alive", '1);
        @(posedge clk); #1;

        // Kill (4,9) so hit_row/hit_col carry a distinctive value
        do_frame(40, 32, 257, 97);
        wait_scan(p, i);
        chk("s4b_pulse_cycle", p, 55);
        chk("s4b_hit_col", int'(hit_col), 9);

        // Abort a scan for index 54 with wave_reset at cycle 20; frame at cycle 10 is ignored
        do_frame(40, 32, 285, 98);
        seen = 0;
        for (int c = 1; c <= 70; c++) begin
            frame = (c == 10);
            wave_reset = (c == 20);
            @(negedge clk);
            if (c == 20) chk("s5_busy_c20", int'(busy), 1);
            if (c == 21) chk("s5_busy_c21", int'(busy), 0);
            if (invader_collision) seen = 1;
            @(posedge clk); #1;
        end
        frame = 1'b0;
        wave_reset = 1'b0;
        chk("s5_no_pulse", seen, 0);
        chk_alive("s5_alive", '1);
        chk("s5_hit_row_kept", int'(hit_row), 4);
        chk("s5_hit_col_kept", int'(hit_col), 9);

        // Asynchronous reset in the middle of a scan
        do_frame(40, 32, 285, 98);
        repeat (9) @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk("s6_busy", int'(busy), 0);
        chk("s6_collision", int'(invader_collision), 0);
        chk("s6_hit_row", int'(hit_row), 0);
        chk("s6_hit_col", int'(hit_col), 0);
        chk("s6_count", int'(alive_count), 55);
        @(posedge clk); #1;
        arst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (invader_collision || busy) seen = 1;
        end
        @(posedge clk); #1;
        chk("s6_quiet_after", seen, 0);

        // Kill the whole formation one frame at a time
        for (int k = 0; k < 55; k++) begin
            do_frame(40, 32, 40 + 24 * (k % 11) + 1, 32 + 16 * (k / 11) + 1);
            wait_scan(p, i);
            chk("s7_pulse_cycle", p, k + 2);
        end
        chk("s7_all_dead", int'(all_dead), 1);
        chk("s7_count0", int'(alive_count), 0);
        chk_alive("s7_alive0", '0);
        do_frame(40, 32, 41, 33);
        @(negedge clk);
        chk("s7_dead_busy", int'(busy), 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
